// File: rtl/tlc_pkg.sv
// Shared types and constants for the adaptive traffic light controller:
// state codes, one-hot lamp encodings and the lamp decode helper.
package tlc_pkg;

  // Controller states; code 3'd7 is never entered on purpose.
  typedef enum logic [2:0] {
    ST_EW_G  = 3'd0,
    ST_EW_Y  = 3'd1,
    ST_AR1   = 3'd2,
    ST_NS_G  = 3'd3,
    ST_NS_Y  = 3'd4,
    ST_AR2   = 3'd5,
    ST_FLASH = 3'd6
  } tlc_state_e;

  localparam logic [2:0] LAMP_G   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ew;
    logic [2:0] ns;
  } lamp_pair_t;

  // Lamp pattern shown in a given state; anything unknown shows red/red.
  function automatic lamp_pair_t lamp_decode(input tlc_state_e st, input logic flash_ph);
    lamp_pair_t lp;
    lp.ew = LAMP_R;
    lp.ns = LAMP_R;
    case (st)
      ST_EW_G: begin
        lp.ew = LAMP_G;
        lp.ns = LAMP_R;
      end
      ST_EW_Y: begin
        lp.ew = LAMP_Y;
        lp.ns = LAMP_R;
      end
      ST_AR1, ST_AR2: begin
        lp.ew = LAMP_R;
        lp.ns = LAMP_R;
      end
      ST_NS_G: begin
        lp.ew = LAMP_R;
        lp.ns = LAMP_G;
      end
      ST_NS_Y: begin
        lp.ew = LAMP_R;
        lp.ns = LAMP_Y;
      end
      ST_FLASH: begin
        if (flash_ph) begin
          lp.ew = LAMP_Y;
          lp.ns = LAMP_Y;
        end else begin
          lp.ew = LAMP_OFF;
          lp.ns = LAMP_OFF;
        end
      end
      default: begin
        lp.ew = LAMP_R;
        lp.ns = LAMP_R;
      end
    endcase
    return lp;
  endfunction

endpackage

// File: rtl/tlc_adaptive_if.sv
// Bundle of the controller's tick/request/flash inputs and lamp/phase outputs.
// The master side (tick generator, detectors, harness) drives the inputs;
// the slave side is the controller itself.
interface tlc_adaptive_if;
  logic       tick;
  logic       ns_req;
  logic       ew_req;
  logic       flash;
  logic [2:0] EW;
  logic [2:0] NS;
  logic [2:0] phase;

  modport master (
    output tick, ns_req, ew_req, flash,
    input  EW, NS, phase
  );

  modport slave (
    input  tick, ns_req, ew_req, flash,
    output EW, NS, phase
  );
endinterface

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts ticks spent in the current phase, clears on request
// and saturates at all-ones so a stuck phase can never wrap back to zero.
module tlc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise advance on tick until saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (tick && (count_q != CNT_SAT)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tlc_adaptive.sv
// Demand-actuated EW/NS traffic light controller with min/max green,
// request-driven green cut-short, all-red clearance and flashing-yellow mode.
// Lamps are registered from the next-state decode so they always match the
// state register without an extra cycle of latency.
module tlc_adaptive
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  tlc_adaptive_if.slave  bus
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Reject durations that are zero, inverted or do not fit the timer.
  if ((CNT_W < 1) || (CNT_W > 32) || (GREEN_MIN < 1) || (GREEN_MAX < GREEN_MIN) ||
      (YELLOW_T < 1) || (ALLRED_T < 1) ||
      (longint'(GREEN_MAX) > CNT_MAX) || (longint'(YELLOW_T) > CNT_MAX) ||
      (longint'(ALLRED_T) > CNT_MAX)) begin : g_bad_params
    $fatal(1, "tlc_adaptive: illegal timing parameters");
  end

  // Timer value seen during the last tick of each duration.
  localparam logic [CNT_W-1:0] G_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_T - 1);

  tlc_state_e       state_q;
  tlc_state_e       state_d;
  tlc_state_e       seq_next;
  logic             req_ns_q;
  logic             req_ns_d;
  logic             req_ew_q;
  logic             req_ew_d;
  logic             flash_ph_q;
  logic             flash_ph_d;
  logic [2:0]       ew_q;
  logic [2:0]       ns_q;
  lamp_pair_t       lamps_d;
  logic             state_chg;
  logic [CNT_W-1:0] timer_cnt;

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .tick  (bus.tick),
    .count (timer_cnt)
  );

  // Next state: normal phase sequencing, then flash overrides everything.
  // An unexpected state code falls into all-red clearance before EW green.
  always_comb begin
    seq_next = state_q;
    case (state_q)
      ST_EW_G: seq_next = (bus.tick && (((timer_cnt >= G_MIN_LAST) && req_ns_q) ||
                                        (timer_cnt >= G_MAX_LAST))) ? ST_EW_Y : ST_EW_G;
      ST_EW_Y: seq_next = (bus.tick && (timer_cnt >= Y_LAST))  ? ST_AR1  : ST_EW_Y;
      ST_AR1:  seq_next = (bus.tick && (timer_cnt >= AR_LAST)) ? ST_NS_G : ST_AR1;
      ST_NS_G: seq_next = (bus.tick && (((timer_cnt >= G_MIN_LAST) && req_ew_q) ||
                                        (timer_cnt >= G_MAX_LAST))) ? ST_NS_Y : ST_NS_G;
      ST_NS_Y: seq_next = (bus.tick && (timer_cnt >= Y_LAST))  ? ST_AR2  : ST_NS_Y;
      ST_AR2:  seq_next = (bus.tick && (timer_cnt >= AR_LAST)) ? ST_EW_G : ST_AR2;
      ST_FLASH: seq_next = bus.flash ? ST_FLASH : ST_AR2;
      default: seq_next = ST_AR2;
    endcase

    if (bus.flash && (state_q != ST_FLASH)) begin
      state_d = ST_FLASH;
    end else begin
      state_d = seq_next;
    end

    state_chg = (state_d != state_q);
  end

  // Request latches, flash blink phase and the lamp pattern for the next state.
  // A request seen on the cycle its green is entered is already being served.
  always_comb begin
    if (state_chg && (state_d == ST_NS_G)) begin
      req_ns_d = 1'b0;
    end else if (bus.ns_req) begin
      req_ns_d = 1'b1;
    end else begin
      req_ns_d = req_ns_q;
    end

    if (state_chg && (state_d == ST_EW_G)) begin
      req_ew_d = 1'b0;
    end else if (bus.ew_req) begin
      req_ew_d = 1'b1;
    end else begin
      req_ew_d = req_ew_q;
    end

    if (state_chg && (state_d == ST_FLASH)) begin
      flash_ph_d = 1'b1;
    end else if ((state_d == ST_FLASH) && bus.tick) begin
      flash_ph_d = ~flash_ph_q;
    end else if (state_d != ST_FLASH) begin
      flash_ph_d = 1'b0;
    end else begin
      flash_ph_d = flash_ph_q;
    end

    lamps_d = lamp_decode(state_d, flash_ph_d);
  end

  // Controller state, latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EW_G;
      req_ns_q   <= 1'b0;
      req_ew_q   <= 1'b0;
      flash_ph_q <= 1'b0;
      ew_q       <= LAMP_G;
      ns_q       <= LAMP_R;
    end else begin
      state_q    <= state_d;
      req_ns_q   <= req_ns_d;
      req_ew_q   <= req_ew_d;
      flash_ph_q <= flash_ph_d;
      ew_q       <= lamps_d.ew;
      ns_q       <= lamps_d.ns;
    end
  end

  assign bus.EW    = ew_q;
  assign bus.NS    = ns_q;
  assign bus.phase = state_q;

endmodule
